// File: rtl/sevenseg_capture.sv
// sevenseg_capture: receive side of a multiplexed, active-low 7-segment/anode bus.
// Qualifies each digit pattern for stability and decodes it into a per-digit hex shadow.
`default_nettype none

module sevenseg_capture #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   an_in,
  input  logic                    err_clr,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    upd_valid,
  output logic [2:0]              upd_idx,
  output logic [3:0]              upd_nibble,
  output logic                    err
);

  localparam int            SW      = NUM_DIGITS + 7;
  localparam int            CW      = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] sample_q;
  logic [SW-1:0] ref_q, ref_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          commit;

  logic [3:0]    zeros;
  logic [2:0]    hot_idx;
  logic          one_hot;

  logic [3:0]    dec_nib;
  logic          dec_legal;
  logic          dec_blank;

  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d;
  logic                    upd_valid_q, upd_valid_d;
  logic [2:0]              idx_q, idx_d;
  logic [3:0]              nib_q, nib_d;
  logic                    err_q, err_d;

  always_comb begin
    zeros   = 4'd0;
    hot_idx = 3'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!sample_q[7+i]) begin
        zeros   = zeros + 4'd1;
        hot_idx = 3'(i);
      end
    end
  end

  assign one_hot = (zeros == 4'd1);

  always_comb begin
    dec_nib   = 4'h0;
    dec_legal = 1'b1;
    case (sample_q[6:0])
      7'b1000000: dec_nib = 4'h0;
      7'b1111001: dec_nib = 4'h1;
      7'b0100100: dec_nib = 4'h2;
      7'b0110000: dec_nib = 4'h3;
      7'b0011001: dec_nib = 4'h4;
      7'b0010010: dec_nib = 4'h5;
      7'b0000010: dec_nib = 4'h6;
      7'b1111000: dec_nib = 4'h7;
      7'b0000000: dec_nib = 4'h8;
      7'b0011000: dec_nib = 4'h9;
      7'b0001000: dec_nib = 4'hA;
      7'b0000011: dec_nib = 4'hB;
      7'b1000110: dec_nib = 4'hC;
      7'b0100001: dec_nib = 4'hD;
      7'b0000110: dec_nib = 4'hE;
      7'b0001110: dec_nib = 4'hF;
      default:    dec_legal = 1'b0;
    endcase
    dec_blank = (sample_q[6:0] == 7'h7F);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_q <= '1;
      ref_q    <= '1;
      cnt_q    <= '0;
      state_q  <= IDLE;
    end else begin
      sample_q <= {an_in, seg_in};
      ref_q    <= ref_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
    end
  end

  // LOCKED shares COUNT's change handling but never advances the counter again.
  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (one_hot) begin
          ref_d   = sample_q;
          cnt_d   = CNT_ONE;
          state_d = COUNT;
        end
      end
      COUNT, LOCKED: begin
        if (sample_q == ref_q) begin
          if (state_q == COUNT) begin
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_d == CNT_MAX) begin
              commit  = 1'b1;
              state_d = LOCKED;
            end
          end
        end else if (one_hot) begin
          ref_d   = sample_q;
          cnt_d   = CNT_ONE;
          state_d = COUNT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A commit only happens when sample equals ref, so the sample drives the decode.
  always_comb begin
    digits_d    = digits_q;
    valid_d     = valid_q;
    upd_valid_d = 1'b0;
    idx_d       = idx_q;
    nib_d       = nib_q;
    err_d       = err_q;
    if (err_clr) begin
      err_d = 1'b0;
    end
    if (commit) begin
      upd_valid_d = 1'b1;
      idx_d       = hot_idx;
      nib_d       = dec_legal ? dec_nib : 4'h0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (hot_idx == 3'(i)) begin
          digits_d[4*i +: 4] = nib_d;
          valid_d[i]         = dec_legal;
        end
      end
      if (!dec_legal && !dec_blank) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_q    <= '0;
      valid_q     <= '0;
      upd_valid_q <= 1'b0;
      idx_q       <= 3'd0;
      nib_q       <= 4'h0;
      err_q       <= 1'b0;
    end else begin
      digits_q    <= digits_d;
      valid_q     <= valid_d;
      upd_valid_q <= upd_valid_d;
      idx_q       <= idx_d;
      nib_q       <= nib_d;
      err_q       <= err_d;
    end
  end

  assign digits      = digits_q;
  assign digit_valid = valid_q;
  assign upd_valid   = upd_valid_q;
  assign upd_idx     = idx_q;
  assign upd_nibble  = nib_q;
  assign err         = err_q;

endmodule

`default_nettype wire

// File: tb/tb_sevenseg_capture.sv
// tb_sevenseg_capture: directed and random stimulus for sevenseg_capture, checked
// against a run-length reference model of the stability/commit rules.
`default_nettype none

module tb_sevenseg_capture;

  localparam int ND = 4;
  localparam int SC = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [6:0]    seg_in = 7'h7F;
  logic [ND-1:0] an_in = '1;
  logic          err_clr = 1'b0;

  logic [4*ND-1:0] digits;
  logic [ND-1:0]   digit_valid;
  logic            upd_valid;
  logic [2:0]      upd_idx;
  logic [3:0]      upd_nibble;
  logic            err;

  sevenseg_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .an_in(an_in), .err_clr(err_clr),
    .digits(digits), .digit_valid(digit_valid), .upd_valid(upd_valid),
    .upd_idx(upd_idx), .upd_nibble(upd_nibble), .err(err)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int pulses   = 0;

  logic [6:0] code_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Reference model: length of the current run of identical one-hot samples.
  logic [ND+6:0] m_prev;
  int            m_run;
  bit            m_pend;
  logic [ND+6:0] m_pend_s;
  logic [3:0]    m_dig [ND];
  bit            m_val [ND];
  bit            m_err;
  bit            m_upd;
  int            m_idx;
  logic [3:0]    m_nib;

  task automatic model_reset();
    m_prev = '1; m_run = 0; m_pend = 0; m_pend_s = '1;
    for (int i = 0; i < ND; i++) begin m_dig[i] = 4'h0; m_val[i] = 0; end
    m_err = 0; m_upd = 0; m_idx = 0; m_nib = 4'h0;
  endtask

  task automatic model_edge();
    logic [ND+6:0] s;
    logic [6:0]    seg;
    int            z;
    int            idx;
    bit            legal;
    logic [3:0]    nib;
    m_upd = m_pend;
    if (m_pend) begin
      seg = m_pend_s[6:0];
      legal = 0; nib = 4'h0; idx = 0;
      for (int k = 0; k < 16; k++) if (code_tab[k] == seg) begin legal = 1; nib = 4'(k); end
      for (int i = 0; i < ND; i++) if (!m_pend_s[7+i]) idx = i;
      m_dig[idx] = nib; m_val[idx] = legal; m_idx = idx; m_nib = nib;
      if (!legal && seg != 7'h7F) m_err = 1;
      else if (err_clr) m_err = 0;
    end else if (err_clr) begin
      m_err = 0;
    end
    s = {an_in, seg_in};
    z = 0;
    for (int i = 0; i < ND; i++) if (!an_in[i]) z++;
    if (z != 1) m_run = 0;
    else if (s == m_prev) m_run++;
    else m_run = 1;
    m_prev = s; m_pend = (m_run == SC); m_pend_s = s;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [4*ND-1:0] ed;
    logic [ND-1:0]   ev;
    for (int i = 0; i < ND; i++) begin ed[4*i +: 4] = m_dig[i]; ev[i] = m_val[i]; end
    if (upd_valid === 1'b1) pulses++;
    chk("upd_valid", 32'(upd_valid), 32'(m_upd));
    chk("upd_idx", 32'(upd_idx), 32'(m_idx));
    chk("upd_nibble", 32'(upd_nibble), 32'(m_nib));
    chk("digits", 32'(digits), 32'(ed));
    chk("digit_valid", 32'(digit_valid), 32'(ev));
    chk("err", 32'(err), 32'(m_err));
  endtask

  // Called at a negedge; drives inputs, lets one posedge pass, checks at the next negedge.
  task automatic step(input logic [ND-1:0] an, input logic [6:0] seg, input bit clr);
    an_in = an; seg_in = seg; err_clr = clr;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_digits", 32'(digits), 32'h0);
    chk("rst_valid", 32'(digit_valid), 32'h0);
    chk("rst_upd", 32'(upd_valid), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    check_all();
  endtask

  initial begin
    logic [ND-1:0] an;
    logic [6:0]    seg;
    int            first_at;
    int            hold;
    model_reset();
    repeat (3) @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // Commit timing on digit 0
    pulses = 0;
    for (int j = 0; j < 10; j++) step(4'b1110, 7'b0110000, 0);
    chk("t2_pulses", 32'(pulses), 32'd1);
    chk("t2_digit0", 32'(digits[3:0]), 32'h3);
    chk("t2_valid", 32'(digit_valid), 32'b0001);

    // Glitch rejection on digit 1
    pulses = 0; first_at = -1;
    for (int j = 0; j < 3; j++) step(4'b1101, 7'b0000010, 0);
    chk("t3_glitch", 32'(pulses), 32'd0);
    for (int j = 1; j <= 8; j++) begin
      step(4'b1101, 7'b0001110, 0);
      if (upd_valid === 1'b1 && first_at < 0) first_at = j;
    end
    chk("t3_pulses", 32'(pulses), 32'd1);
    chk("t3_latency", 32'(first_at), 32'd5);
    chk("t3_nibble", 32'(digits[7:4]), 32'hF);

    // Multiplex scan, two passes
    pulses = 0;
    for (int p = 0; p < 2; p++) begin
      for (int j = 0; j < 8; j++) step(4'b1110, 7'b1111001, 0);
      for (int j = 0; j < 8; j++) step(4'b1101, 7'b0001000, 0);
      for (int j = 0; j < 8; j++) step(4'b1011, 7'b0000011, 0);
      for (int j = 0; j < 8; j++) step(4'b0111, 7'b0011000, 0);
    end
    chk("t4_digits", 32'(digits), 32'h9BA1);
    chk("t4_valid", 32'(digit_valid), 32'hF);
    chk("t4_pulses", 32'(pulses), 32'd8);

    // Asynchronous reset mid-operation
    async_reset();

    // Blank and illegal on digit 2, err_clr behaviour
    for (int j = 0; j < 6; j++) step(4'b1011, 7'b1111111, 0);
    chk("t5_blank_valid", 32'(digit_valid[2]), 32'd0);
    chk("t5_blank_err", 32'(err), 32'd0);
    for (int j = 0; j < 6; j++) step(4'b1011, 7'b1010101, 0);
    chk("t5_illegal_err", 32'(err), 32'd1);
    step(4'b1011, 7'b1010101, 1);
    chk("t5_clr", 32'(err), 32'd0);
    for (int j = 0; j < 4; j++) step(4'b1110, 7'b1100110, 0);
    step(4'b1110, 7'b1100110, 1);
    chk("t5_set_wins", 32'(err), 32'd1);
    step(4'b1110, 7'b1100110, 0);

    // Not one-hot anodes
    pulses = 0;
    for (int j = 0; j < 20; j++) step(4'b1100, 7'b0100100, 0);
    for (int j = 0; j < 20; j++) step(4'b1111, 7'b0100100, 0);
    chk("t6_pulses", 32'(pulses), 32'd0);

    // Reset during a partial count
    pulses = 0;
    step(4'b1110, 7'b0010010, 0);
    step(4'b1110, 7'b0010010, 0);
    async_reset();
    for (int j = 0; j < 6; j++) step(4'b1111, 7'b0010010, 0);
    chk("t7_pulses", 32'(pulses), 32'd0);

    // Randomized episodes
    for (int e = 0; e < 300; e++) begin
      if ($urandom_range(4, 0) == 0) begin
        an = ND'($urandom);
      end else begin
        an = '1;
        an[$urandom_range(ND-1, 0)] = 1'b0;
      end
      case ($urandom_range(9, 0))
        0:       seg = 7'h7F;
        1:       seg = 7'($urandom);
        default: seg = code_tab[$urandom_range(15, 0)];
      endcase
      hold = int'($urandom_range(7, 1));
      for (int j = 0; j < hold; j++) step(an, seg, ($urandom_range(7, 0) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sevenseg_capture.md
Name: sevenseg_capture

Overview:
- Receive end of the 7-segment display bus: the inverse of the hex-to-segment encoder.
- Watches a multiplexed, active-low segment/anode bus, which can come from on-chip drivers or an external display under test.
- Qualifies each digit pattern for stability, decodes it back to a 4-bit hex value and keeps a per-digit shadow register.
- Used in lab self-check logic and display loopback tests.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits, equal to the anode bus width; range 1..8.
- STABLE_CYCLES, 4: consecutive identical samples required before a digit is committed; minimum 2, maximum 255.

Ports:
- clk  input  1  system clock; all logic rises on posedge.
- rst_n  input  1  asynchronous active-low reset, released synchronously by the user.
- seg_in  input  7  segment bus, active-low, bit 6 = g ... bit 0 = a.
- an_in  input  NUM_DIGITS  digit enables, active-low; exactly one low selects a digit.
- err_clr  input  1  synchronous clear of the sticky error flag.
- digits  output  4*NUM_DIGITS  decoded nibbles; digit i occupies bits [4i+3:4i].
- digit_valid  output  NUM_DIGITS  digit i holds a legal decoded value.
- upd_valid  output  1  one-cycle pulse on each commit.
- upd_idx  output  3  index of the committed digit.
- upd_nibble  output  4  value committed; 0 for blank or illegal patterns.
- err  output  1  sticky flag: an illegal pattern was committed.

Behaviour:
- Reset (async, rst_n low): all outputs 0, FSM to IDLE, sample and reference registers to all-ones (blank, no anode), counter 0.
- Input stage: {an_in, seg_in} is registered every cycle into a sample register. No synchronizer is included; external sources are synchronized upstream.
- Sample qualification: a sample is "one-hot" when exactly one an bit is 0.
- FSM, three states:
  - IDLE: the sample is not one-hot. On a one-hot sample: ref <= sample, cnt <= 1, go to COUNT.
  - COUNT:
    - Sample == ref: cnt <= cnt+1. When cnt+1 == STABLE_CYCLES, commit and go to LOCKED.
    - Sample != ref and one-hot: ref <= sample, cnt <= 1, stay in COUNT.
    - Sample not one-hot: go to IDLE.
  - LOCKED: hold while sample == ref. On any change, apply the same rules as COUNT (restart or IDLE). There is never a second commit without a change.
- Latency: if a pattern is first sampled at edge 0 and held, upd_valid is high in the cycle after edge STABLE_CYCLES. There is exactly one pulse per stable episode.
- Decode table (seg to nibble): 1000000=0, 1111001=1, 0100100=2, 0110000=3, 0011001=4, 0010010=5, 0000010=6, 1111000=7, 0000000=8, 0011000=9, 0001000=A, 0000011=b, 1000110=C, 0100001=d, 0000110=E, 0001110=F.
- Commit of digit i (i = index of the low an bit):
  - Legal pattern: digits[i] <= nibble, digit_valid[i] <= 1.
  - Blank (1111111): digits[i] <= 0, digit_valid[i] <= 0, no error.
  - Any other pattern: digits[i] <= 0, digit_valid[i] <= 0, err <= 1.
  - In all three cases: upd_valid <= 1, upd_idx <= i, upd_nibble <= the value written.
- upd_idx / upd_nibble: hold their last value when upd_valid is 0.
- err_clr: clears err. If a commit sets err in the same cycle, the set wins.
- Counter: never exceeds STABLE_CYCLES; width is ceil(log2(STABLE_CYCLES+1)).
- Boundary cases:
  - A pattern that changes in the same cycle cnt would reach the threshold does not commit.
  - Multiple low anodes and all-high anodes are both treated as not one-hot.
  - Reset asserted mid-count discards the partial count; no pulse is generated.

Test Plan:
- Reset: rst_n low mid-operation -> digits=0, digit_valid=0, upd_valid=0, err=0 immediately, without a clock edge.
- Commit timing: an_in=1110, seg_in=0110000 held 10 cycles (STABLE_CYCLES=4) -> one upd_valid pulse after edge 4, upd_idx=0, upd_nibble=3, digits[3:0]=3, digit_valid=0001.
- Glitch rejection: seg_in=0000010 for 3 cycles then 0001110 held, an_in=1101 -> no commit for 6; single commit idx=1, nibble=F, 4 edges after the change.
- Multiplex scan: rotate an_in 1110/1101/1011/0111 every 8 cycles with codes for 1,A,b,9 -> digits=16'h9BA1, digit_valid=1111, 4 pulses per scan.
- Blank and illegal: digit 2 shows 1111111 -> digit_valid[2]=0, err=0; then 1010101 -> err=1. err_clr pulsed -> err=0. err_clr coincident with another illegal commit -> err stays 1.
- Not one-hot: an_in=1100 or 1111 with a valid seg_in held 20 cycles -> no upd_valid, and all registers unchanged.
